// File: rtl/prefix_adder_if.sv
// ----------------------------------------------------------------------------
// prefix_adder_if
//   Operand/result bundle for prefix_adder_pipe.
//
//   Handshake: a beat moves on a rising clk edge when valid && ready are both
//   high at that edge. A producer holds valid and its data stable until the
//   beat is taken. in_ready depends on out_valid/out_ready only, never on
//   in_valid. While out_valid && !out_ready, y/cout/ovf are held unchanged.
//
//   Signals (producer drives operands and out_ready; adder drives the rest):
//     in_valid, in_ready    operand handshake
//     a, b [WIDTH]          operands
//     cin                   carry-in, used in add mode only
//     sub                   0 = A + B + cin, 1 = A - B
//     out_valid, out_ready  result handshake
//     y [WIDTH]             sum / difference
//     cout                  carry-out (not-borrow when subtracting)
//     ovf                   signed two's-complement overflow
//
//   Modports: master = operand producer / result consumer, slave = the adder.
// ----------------------------------------------------------------------------
interface prefix_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
endinterface

// File: rtl/prefix_adder_pipe.sv
// ----------------------------------------------------------------------------
// prefix_adder_pipe
//   Pipelined Kogge-Stone adder/subtractor with valid/ready at both ends.
//   Datapath: generate/propagate pre-stage, $clog2(WIDTH) prefix levels, sum
//   post-stage. PIPE register cuts are spread evenly over those levels; the
//   last cut always sits after the post-stage so outputs come straight from
//   flops. Latency is PIPE cycles, throughput one result per cycle.
//
//   Parameters: WIDTH (4..64), PIPE (1..$clog2(WIDTH)+1).
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  prefix_adder_if.slave (operand and result handshakes)
//
//   Build option: define PREFIX_ADDER_SAT_EN to clamp y to the signed
//   max/min on overflow (ovf and cout unchanged). Without it y wraps.
// ----------------------------------------------------------------------------
module prefix_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input logic           clk,
    input logic           rst,
    prefix_adder_if.slave bus
);
    localparam int LVLS = $clog2(WIDTH);
    // Logic levels available for cuts: pre-stage, prefix levels, post-stage.
    localparam int SPAN = LVLS + 2;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] g;   // group generate
        logic [WIDTH-1:0] p;   // group propagate
        logic [WIDTH-1:0] x;   // bitwise a ^ Be, needed again for the sum
        logic             ce;  // effective carry-in
        logic             am;  // a[MSB], for overflow
        logic             bm;  // Be[MSB], for overflow
    } lvl_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] y;
        logic             cout;
        logic             ovf;
    } res_t;

    // Level k is followed by a register when the even spread of PIPE cuts
    // over SPAN levels steps up at k. Since PIPE < SPAN the step is at most
    // one per level, and the post-stage (k = SPAN-1) always gets a cut.
    function automatic logic cut_after(input int k);
        return (((k + 1) * PIPE) / SPAN) != ((k * PIPE) / SPAN);
    endfunction

    logic advance;
    res_t res_d;
    res_t res_q;

    // Whole pipe moves together; a stall freezes bubbles too.
    assign advance       = !res_q.vld || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = res_q.vld;
    assign bus.y         = res_q.y;
    assign bus.cout      = res_q.cout;
    assign bus.ovf       = res_q.ovf;

    for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
        lvl_t lvl_d;
        lvl_t lvl_o;

        if (k == 0) begin : g_pre
            logic [WIDTH-1:0] be;
            assign be = bus.sub ? ~bus.b : bus.b;

            always_comb begin
                lvl_d     = '0;
                lvl_d.vld = bus.in_valid && advance;
                lvl_d.g   = bus.a & be;
                lvl_d.p   = bus.a ^ be;
                lvl_d.x   = bus.a ^ be;
                lvl_d.ce  = bus.sub ? 1'b1 : bus.cin;
                lvl_d.am  = bus.a[WIDTH-1];
                lvl_d.bm  = be[WIDTH-1];
            end
        end else begin : g_ks
            localparam int DIST = 1 << (k - 1);

            always_comb begin
                lvl_d = g_lvl[k-1].lvl_o;
                for (int i = DIST; i < WIDTH; i++) begin
                    lvl_d.g[i] = g_lvl[k-1].lvl_o.g[i] |
                                 (g_lvl[k-1].lvl_o.p[i] & g_lvl[k-1].lvl_o.g[i-DIST]);
                    lvl_d.p[i] = g_lvl[k-1].lvl_o.p[i] & g_lvl[k-1].lvl_o.p[i-DIST];
                end
            end
        end

        if (cut_after(k)) begin : g_cut
            lvl_t lvl_q;

            // Data only loads with a valid beat so bubbles never disturb it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lvl_q <= '0;
                end else if (advance) begin
                    if (lvl_d.vld) begin
                        lvl_q <= lvl_d;
                    end else begin
                        lvl_q.vld <= 1'b0;
                    end
                end
            end

            assign lvl_o = lvl_q;
        end else begin : g_pass
            assign lvl_o = lvl_d;
        end
    end

    lvl_t post_in;
    assign post_in = g_lvl[LVLS].lvl_o;

    // Post-stage: carry into bit i is G[i-1:0] | P[i-1:0] & ce.
    always_comb begin
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] sum;

        c    = '0;
        c[0] = post_in.ce;
        for (int i = 1; i < WIDTH; i++) begin
            c[i] = post_in.g[i-1] | (post_in.p[i-1] & post_in.ce);
        end
        sum = post_in.x ^ c;

        res_d      = '0;
        res_d.vld  = post_in.vld;
        res_d.cout = post_in.g[WIDTH-1] | (post_in.p[WIDTH-1] & post_in.ce);
        res_d.ovf  = (post_in.am == post_in.bm) && (sum[WIDTH-1] != post_in.am);
`ifdef PREFIX_ADDER_SAT_EN
        // Overflow can only happen with equal operand signs, so a[MSB]
        // tells the direction: 0 -> positive overflow, 1 -> negative.
        if (res_d.ovf) begin
            res_d.y = post_in.am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_d.y = sum;
        end
`else
        res_d.y = sum;
`endif
    end

    // Output register: y/cout/ovf keep their last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (advance) begin
            if (res_d.vld) begin
                res_q <= res_d;
            end else begin
                res_q.vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_prefix_adder_pipe
//   Self-checking bench for prefix_adder_pipe. WIDTH/PIPE are overridable.
//   Expected results come from an arithmetic reference model (signed range
//   test for ovf, unsigned compare/carry for cout); directed cases use
//   hand-derived constants. A negedge monitor keeps the scoreboard queue,
//   checks output stability during stalls/bubbles and in_ready under stall.
// ----------------------------------------------------------------------------
module tb_prefix_adder_pipe;
    parameter int WIDTH = 32;
    parameter int PIPE  = 2;

    localparam int CW = WIDTH + 2;
    typedef logic [CW-1:0] cv_t;

    logic clk;
    logic rst;

    prefix_adder_if #(.WIDTH(WIDTH)) bus ();

    prefix_adder_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int  n_checks  = 0;
    int  n_errors  = 0;
    int  n_sent    = 0;
    int  n_recv    = 0;
    int  n_dropped = 0;
    int  ready_mode = 0;   // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: always 0
    cv_t cur_exp;
    cv_t exp_q[$];

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] smax;
    logic [WIDTH-1:0] smin;

    task automatic check(input string tag, input cv_t obs, input cv_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model, result packed as {ovf, cout, y}.
    function automatic cv_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input logic sub);
        logic signed [WIDTH+1:0] sa;
        logic signed [WIDTH+1:0] sb;
        logic signed [WIDTH+1:0] r;
        logic signed [WIDTH+1:0] hi;
        logic signed [WIDTH+1:0] lo;
        logic [WIDTH:0]          u;
        logic                    co;
        logic                    ov;
        logic [WIDTH-1:0]        y;
        sa = $signed({{2{a[WIDTH-1]}}, a});
        sb = $signed({{2{b[WIDTH-1]}}, b});
        hi = $signed({3'b000, {(WIDTH-1){1'b1}}});
        lo = -hi - 1;
        if (sub) begin
            r  = sa - sb;
            co = (a >= b);
        end else begin
            r = sa + sb;
            if (cin) r = r + 1;
            u  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            co = u[WIDTH];
        end
        ov = (r > hi) || (r < lo);
        y  = r[WIDTH-1:0];
`ifdef PREFIX_ADDER_SAT_EN
        if (ov) y = (r > hi) ? hi[WIDTH-1:0] : lo[WIDTH-1:0];
`endif
        return {ov, co, y};
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return ones;
            2:       return smax;
            3:       return smin;
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input cv_t exp, output int waits);
        logic accepted;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        cur_exp      = exp;
        waits        = 0;
        accepted     = 1'b0;
        while (!accepted && waits <= 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            if (!accepted) waits++;
            @(posedge clk);
            #1;
        end
        if (!accepted) check("accept_timeout", cv_t'(waits), '0);
    endtask

    task automatic drive_rand(output int waits);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        a   = rand_word();
        b   = rand_word();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        drive(a, b, cin, sub, ref_model(a, b, cin, sub), waits);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", cv_t'(exp_q.size()), '0);
    endtask

    // out_ready driver
    initial begin
        int cyc;
        cyc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic prev_stall;
    logic prev_idle;
    cv_t  prev_obs;

    always @(negedge clk) begin
        cv_t obs;
        obs = {bus.ovf, bus.cout, bus.y};
        if (rst) begin
            prev_stall = 1'b0;
            prev_idle  = 1'b0;
        end else begin
            if (prev_stall || (prev_idle && !bus.out_valid))
                check("hold", obs, prev_obs);
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_stall", cv_t'(bus.in_ready), '0);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(cur_exp);
                n_sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious", cv_t'(bus.out_valid), '0);
                end else begin
                    check("result", obs, exp_q.pop_front());
                    n_recv++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_idle  = !bus.out_valid;
            prev_obs   = obs;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int   w;
        int   total_w;
        int   k;
        int   n_fill;
        cv_t  e;
        logic [WIDTH-1:0] t;

        ones = '1;
        smax = ones >> 1;
        smin = ~smax;
        rst  = 1'b1;
        cur_exp = '0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", cv_t'(bus.out_valid), '0);
        check("reset_outputs", {bus.ovf, bus.cout, bus.y}, '0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", cv_t'(bus.in_ready), cv_t'(1));
        @(posedge clk);
        #1;

        // All-ones + 1: wraps to zero with carry out; also measures latency.
        e = '0;
        e[WIDTH] = 1'b1;
        drive(ones, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b0, e, w);
        idle();
        k = 1;
        while (!bus.out_valid && k <= PIPE + 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", cv_t'(k), cv_t'(PIPE));
        drain();

        // 5 - 7 = -2, borrow (cout = 0)
        t = '1;
        t[0] = 1'b0;
        e = {2'b00, t};
        drive(WIDTH'(5), WIDTH'(7), 1'b0, 1'b1, e, w);
        // signed max + 1 overflows
`ifdef PREFIX_ADDER_SAT_EN
        e = {2'b10, smax};
`else
        e = {2'b10, smin};
`endif
        drive(smax, WIDTH'(1), 1'b0, 1'b0, e, w);
        // cin ignored when subtracting: 7 - 7 = 0, no borrow
        e = {2'b01, {WIDTH{1'b0}}};
        drive(WIDTH'(7), WIDTH'(7), 1'b1, 1'b1, e, w);
        idle();
        drain();

        // Backpressure: a = i, b = 3i with out_ready 1,0,0,...
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            drive(WIDTH'(i), WIDTH'(3 * i), 1'b0, 1'b0,
                  ref_model(WIDTH'(i), WIDTH'(3 * i), 1'b0, 1'b0), w);
        end
        idle();
        drain();
        ready_mode = 0;

        // Throughput: 100 back-to-back beats with no stalls expected.
        total_w = 0;
        for (int i = 0; i < 100; i++) begin
            drive_rand(w);
            total_w += w;
        end
        idle();
        check("throughput_waits", cv_t'(total_w), '0);
        drain();

        // Random traffic with random backpressure and input gaps.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            drive_rand(w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        ready_mode = 0;
        drain();

        // Mid-stream reset with results in flight.
        ready_mode = 3;
        @(posedge clk);
        #1;
        n_fill = (PIPE >= 2) ? 2 : 1;
        for (int i = 0; i < n_fill; i++) drive_rand(w);
        idle();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", cv_t'(bus.out_valid), '0);
        check("midrst_outputs", {bus.ovf, bus.cout, bus.y}, '0);
        n_dropped += exp_q.size();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        #1;
        check("midrst_in_ready", cv_t'(bus.in_ready), cv_t'(1));
        repeat (PIPE + 5) @(posedge clk);
        #1;
        check("midrst_no_stale", cv_t'(bus.out_valid), '0);

        // A few more after reset to confirm normal operation.
        for (int i = 0; i < 20; i++) drive_rand(w);
        idle();
        drain();

        check("result_count", cv_t'(n_recv), cv_t'(n_sent - n_dropped));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
